// File: rtl/uart_rcv_fifo.sv
// uart_rcv_fifo: UART receiver with a first-word-fall-through frame FIFO and sticky error flags.
// Optional parity checking is compiled in by defining UART_RCV_PARITY_EN.
module uart_rcv_fifo #(
    parameter int BAUD_DIV   = 2604,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               RX,
    input  logic                               pop,
    input  logic                               clr_err,
    output logic [DATA_BITS-1:0]               rx_data,
    output logic                               rdy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_cnt,
    output logic                               busy,
    output logic                               frm_err,
    output logic                               par_err,
    output logic                               ovr_err
);
    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] HALF_LD  = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LD  = CNT_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
    localparam logic [CW-1:0]    DEPTH    = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RCV_PARITY_EN
        S_PAR,
`endif
        S_STOP,
        S_BRK
    } state_t;

    state_t                 r_state, w_next;
    logic                   r_s1, r_s2, w_rx;
    logic [CNT_W-1:0]       r_cnt;
    logic [BIT_W-1:0]       r_bit;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr, r_rd;
    logic [CW-1:0]          r_fcnt;
    logic                   w_sample, w_start, w_shift, w_push, w_frm;
    logic                   w_pop, w_full, w_wr, w_ovr;
`ifdef UART_RCV_PARITY_EN
    localparam logic ODD = (PARITY_ODD != 0);
    logic                   r_bad, w_chk, w_par;
`else
    logic                   w_unused_odd;
`endif

    assign w_rx     = r_s2;
    assign w_sample = (r_cnt == '0);
    assign busy     = (r_state != S_IDLE);
    assign rx_data  = r_mem[r_rd];
    assign rdy      = (r_fcnt != '0);
    assign fifo_cnt = r_fcnt;
    assign w_pop    = pop && rdy;
    assign w_full   = (r_fcnt == DEPTH);
    assign w_wr     = w_push && (!w_full || w_pop);
    assign w_ovr    = w_push && w_full && !w_pop;

    // Two-flop synchroniser for the asynchronous RX pin, idling high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= RX;
            r_s2 <= r_s1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // FSM next-state and per-cycle strobes
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_shift = 1'b0;
        w_push  = 1'b0;
        w_frm   = 1'b0;
`ifdef UART_RCV_PARITY_EN
        w_chk   = 1'b0;
        w_par   = 1'b0;
`endif
        case (r_state)
            S_IDLE: if (!w_rx) begin
                w_next  = S_START;
                w_start = 1'b1;
            end
            S_START: if (w_sample) w_next = w_rx ? S_IDLE : S_DATA;
            S_DATA: if (w_sample) begin
                w_shift = 1'b1;
`ifdef UART_RCV_PARITY_EN
                if (r_bit == LAST_BIT) w_next = S_PAR;
`else
                if (r_bit == LAST_BIT) w_next = S_STOP;
`endif
            end
`ifdef UART_RCV_PARITY_EN
            S_PAR: if (w_sample) begin
                w_chk  = 1'b1;
                w_next = S_STOP;
            end
`endif
            S_STOP: if (w_sample) begin
                if (!w_rx) begin
                    w_frm  = 1'b1;
                    w_next = S_BRK;
                end else begin
                    w_next = S_IDLE;
`ifdef UART_RCV_PARITY_EN
                    w_push = !r_bad;
                    w_par  = r_bad;
`else
                    w_push = 1'b1;
`endif
                end
            end
            S_BRK: if (w_rx) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Baud counter: half-bit load on start detect, full-bit reload at each sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    r_cnt <= '0;
        else if (w_start)           r_cnt <= HALF_LD;
        else if (r_state != S_IDLE) r_cnt <= w_sample ? FULL_LD : r_cnt - 1'b1;
    end

    // Data shifter, LSB first, with a bit counter cleared at each new frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit   <= '0;
            r_shift <= '0;
        end else if (w_start) begin
            r_bit   <= '0;
        end else if (w_shift) begin
            r_bit   <= r_bit + 1'b1;
            r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
        end
    end

    // Frame FIFO; a push into a full FIFO only lands if a pop frees a slot this cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr   <= '0;
            r_rd   <= '0;
            r_fcnt <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr] <= r_shift;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_fcnt <= r_fcnt + CW'(w_wr) - CW'(w_pop);
        end
    end

    // Sticky framing and overrun flags; a new error wins over clr_err
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frm_err <= 1'b0;
            ovr_err <= 1'b0;
        end else begin
            frm_err <= w_frm ? 1'b1 : (clr_err ? 1'b0 : frm_err);
            ovr_err <= w_ovr ? 1'b1 : (clr_err ? 1'b0 : ovr_err);
        end
    end

`ifdef UART_RCV_PARITY_EN
    // Parity verdict for the current frame plus its sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bad   <= 1'b0;
            par_err <= 1'b0;
        end else begin
            if (w_start)    r_bad <= 1'b0;
            else if (w_chk) r_bad <= (w_rx != ((^r_shift) ^ ODD));
            par_err <= w_par ? 1'b1 : (clr_err ? 1'b0 : par_err);
        end
    end
`else
    assign par_err      = 1'b0;
    assign w_unused_odd = (PARITY_ODD != 0);
`endif
endmodule

// File: doc/uart_rcv_fifo.md
# uart_rcv_fifo

Parametrised UART receiver for the quadcopter serial links. It handles configurable data width and baud divisor and checks optional parity. Frames are buffered in a first-word-fall-through FIFO, so slow consumers do not lose bytes. Framing, parity and overrun errors are flagged with sticky bits. It sits between the asynchronous RX pin and the command/telemetry parsers.

## Interface
Parameters:
- BAUD_DIV, 2604 — clk cycles per bit (50 MHz / 19200); even, ≥ 8
- DATA_BITS, 8 — data bits per frame, 5..9
- FIFO_DEPTH, 4 — frame buffer entries, power of two, ≥ 2
- PARITY_ODD, 0 — 1 = odd parity, 0 = even; only used when parity is compiled in

Ports:
- clk  in  1  system clock; the block uses this single clock
- rst  in  1  asynchronous, active-high reset
- RX  in  1  serial input, asynchronous, idle high
- pop  in  1  consume the head entry; ignored when rdy = 0
- clr_err  in  1  clears all sticky error flags
- rx_data  out  DATA_BITS  FIFO head entry, LSB = first bit received
- rdy  out  1  FIFO not empty
- fifo_cnt  out  $clog2(FIFO_DEPTH+1)  number of entries in the FIFO
- busy  out  1  FSM is not in IDLE
- frm_err  out  1  sticky; stop bit sampled low
- par_err  out  1  sticky; parity mismatch
- ovr_err  out  1  sticky; frame completed while the FIFO was full

## Operation
- RX double-flopped; both flops reset to 1. Only the second flop's output, rx_s, is used.
- Baud counter: loaded on state entry and decremented every cycle outside IDLE. A sample event occurs when the counter is 0; the counter then reloads with BAUD_DIV-1.
- FSM states:
  - IDLE: when rx_s = 0, go to START and load the counter with BAUD_DIV/2-1.
  - START: at the sample event, go to DATA if rx_s = 0; if rx_s = 1 it is a glitch, return to IDLE with no flags set.
  - DATA: shift rx_s in LSB-first at each sample. After DATA_BITS samples go to PAR (parity compiled in) or STOP.
  - PAR: at the sample, compare rx_s with the computed parity. A mismatch marks the frame bad. Then go to STOP.
  - STOP: at the sample:
    - rx_s = 1 and frame good: push into the FIFO and go to IDLE.
    - rx_s = 1 and parity mismatch: set par_err, discard the frame, go to IDLE.
    - rx_s = 0: set frm_err, discard the frame, go to BRK.
  - BRK: wait until rx_s = 1, then go to IDLE. This stops a break condition from re-triggering start detection.
- FIFO:
  - Push when full with no pop in the same cycle: the frame is dropped, ovr_err is set, and FIFO contents are unchanged.
  - Push and pop in the same cycle when full: both are performed; ovr_err is not set.
  - Push and pop in the same cycle when empty: the push is performed; the pop is ignored.
  - Pointers wrap modulo FIFO_DEPTH; fifo_cnt saturates at neither end because over- and underflow are blocked.
- Errors:
  - Set has priority over clr_err in the same cycle.
  - Flags are independent of FIFO state.
- Reset at any point returns the block to IDLE, empties the FIFO and discards any partial frame.

## Timing
- Reset values: rx_data 0 (storage cleared), rdy 0, fifo_cnt 0, busy 0, frm_err 0, par_err 0, ovr_err 0.
- Reference points:
  - t0 is the clk edge at which RX = 0 is first captured.
  - H = BAUD_DIV/2.
  - P = 1 if parity is compiled in, else 0.
- START check occurs at edge t0+2+H.
- Data bit k (k = 0..DATA_BITS-1) is sampled at edge t0+2+H+(k+1)·BAUD_DIV.
- Stop bit is sampled, and the push occurs, at edge t0+2+H+(DATA_BITS+1+P)·BAUD_DIV. rdy, fifo_cnt and rx_data update after that edge.
- busy is 1 from edge t0+2 through the stop sample (and through BRK).
- pop takes effect at the next edge; the following entry is visible on rx_data one cycle after pop.
- Back-to-back frames (stop bit immediately followed by a start bit) are received without loss.

## Configuration
- UART_RCV_PARITY_EN
  - Defined: the PAR state exists, one parity bit follows the data bits, mismatches set par_err, and PARITY_ODD selects the sense.
  - Undefined: there is no PAR state, frames are start + DATA_BITS + stop, and par_err is tied to 0.

## Test plan
- BAUD_DIV=16, 8N1: send 0xA5 → rx_data = 0xA5 and rdy rises after edge t0+2+8+144. Assert pop → rdy = 0, fifo_cnt = 0.
- Send 5 frames 0x01..0x05 with FIFO_DEPTH=4 and no pops → fifo_cnt = 4 and ovr_err = 1. Popping 4 times yields 0x01..0x04. clr_err clears ovr_err.
- Send 0x3C with the stop bit held low for 3 bit times → frm_err = 1, no push, busy stays 1 until RX returns high, then the next frame 0x55 is received correctly.
- RX low pulse of 6 cycles (< H) → FSM returns to IDLE at the START check with no push and no flags.
- With UART_RCV_PARITY_EN defined and PARITY_ODD=0: send 0x07 with parity 1 → accepted. Send 0x07 with parity 0 → par_err = 1 and no push.
- Assert rst mid-frame (during DATA) with 2 entries queued → all outputs return to reset values. A subsequent clean 0x81 is received as the sole entry.
